// File: rtl/cache_dm_param.sv
// cache_dm_param: direct-mapped, multiword, read-only instruction cache.
// Registered hit path, refill FSM with req/ready handshake to main memory,
// and saturating hit/miss counters.
// Optional feature macro: CACHE_FLUSH_EN (adds the flush port).
module cache_dm_param #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned WORDS_PER_BLOCK = 2,
    parameter int unsigned NUM_BLOCKS      = 4,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              req_valid,
    input  logic [31:0]                       PC,
    output logic                              HitWrite,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              rvalid,
    output logic                              mem_req,
    output logic [31:0]                       mem_addr,
    input  logic                              mem_ready,
    input  logic [WORDS_PER_BLOCK*DATA_W-1:0] mem_rdata,
`ifdef CACHE_FLUSH_EN
    input  logic                              flush,
`endif
    output logic [CNT_W-1:0]                  CNT_HIT,
    output logic [CNT_W-1:0]                  CNT_MISS
);

    localparam int unsigned OFF    = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned IDX    = $clog2(NUM_BLOCKS);
    localparam int unsigned TAG_W  = 32 - OFF - IDX - 2;
    localparam int unsigned SEL_W  = (OFF > 0) ? OFF : 1;
    localparam int unsigned LINE_W = WORDS_PER_BLOCK * DATA_W;

    typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

    state_t               state_q, state_d;
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]    line_q [NUM_BLOCKS];
    logic [IDX-1:0]       req_idx_q;
    logic [TAG_W-1:0]     req_tag_q;
    logic [SEL_W-1:0]     req_sel_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rvalid_q;
    logic                 mem_req_q;
    logic [31:0]          mem_addr_q;
    logic [CNT_W-1:0]     cnt_hit_q, cnt_miss_q;

    logic                 flush_w;
    logic [IDX-1:0]       pc_idx;
    logic [TAG_W-1:0]     pc_tag;
    logic [SEL_W-1:0]     pc_sel;
    logic                 hit_w;
    logic [DATA_W-1:0]    hit_word, fill_word;
    logic                 do_hit, do_miss, do_fill, do_flush;
    logic                 unused_pc_lsbs;

`ifdef CACHE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Byte offset within a word is irrelevant for word fetches.
    assign unused_pc_lsbs = ^PC[1:0];

    assign pc_idx = PC[OFF+2 +: IDX];
    assign pc_tag = PC[31 -: TAG_W];

    generate
        if (OFF > 0) begin : g_sel
            assign pc_sel = PC[2 +: SEL_W];
        end else begin : g_nosel
            assign pc_sel = '0;
        end
    endgenerate

    function automatic logic [DATA_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                    input logic [SEL_W-1:0]  sel);
        logic [DATA_W-1:0] word;
        word = '0;
        for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
            if (sel == SEL_W'(w)) word = line[w*DATA_W +: DATA_W];
        end
        return word;
    endfunction

    assign hit_w     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign hit_word  = pick_word(line_q[pc_idx], pc_sel);
    assign fill_word = pick_word(mem_rdata, req_sel_q);

    assign HitWrite = (state_q == IDLE) && !flush_w;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign CNT_HIT  = cnt_hit_q;
    assign CNT_MISS = cnt_miss_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_d  = state_q;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_fill  = 1'b0;
        do_flush = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_w) begin
                    do_flush = 1'b1;
                end else if (req_valid) begin
                    if (hit_w) begin
                        do_hit = 1'b1;
                    end else begin
                        do_miss = 1'b1;
                        state_d = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_ready) begin
                    do_fill = 1'b1;
                    state_d = FILL;
                end
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control/datapath registers: valid bits, response, refill request, counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            req_idx_q  <= '0;
            req_tag_q  <= '0;
            req_sel_q  <= '0;
            cnt_hit_q  <= '0;
            cnt_miss_q <= '0;
        end else begin
            rvalid_q <= do_hit | do_fill;
            if (do_hit) begin
                rdata_q <= hit_word;
                if (cnt_hit_q != '1) cnt_hit_q <= cnt_hit_q + 1'b1;
            end
            if (do_miss) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= {PC[31:OFF+2], {(OFF+2){1'b0}}};
                req_idx_q  <= pc_idx;
                req_tag_q  <= pc_tag;
                req_sel_q  <= pc_sel;
                if (cnt_miss_q != '1) cnt_miss_q <= cnt_miss_q + 1'b1;
            end
            if (do_fill) begin
                mem_req_q          <= 1'b0;
                valid_q[req_idx_q] <= 1'b1;
                rdata_q            <= fill_word;
            end
            if (do_flush) valid_q <= '0;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge CLK) begin
        if (do_fill && !RESET) begin
            tag_q[req_idx_q]  <= req_tag_q;
            line_q[req_idx_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_dm_param.sv
// Self-checking bench for cache_dm_param: scoreboard of expected responses,
// behavioural cache model, random fetch stream and a random-latency memory.
// Flush scenario is compiled in when CACHE_FLUSH_EN is defined.
module tb_cache_dm_param;

    localparam int DW   = 32;
    localparam int WPB  = 2;
    localparam int NB   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MEMW = 64;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               req_valid;
    logic [31:0]        PC;
    logic               HitWrite;
    logic [DW-1:0]      rdata;
    logic               rvalid;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic               mem_ready;
    logic [WPB*DW-1:0]  mem_rdata;
    logic [CW-1:0]      CNT_HIT, CNT_MISS;
`ifdef CACHE_FLUSH_EN
    logic               flush = 1'b0;
`endif

    cache_dm_param #(.DATA_W(DW), .WORDS_PER_BLOCK(WPB), .NUM_BLOCKS(NB), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .PC(PC), .HitWrite(HitWrite),
        .rdata(rdata), .rvalid(rvalid), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
`ifdef CACHE_FLUSH_EN
        .flush(flush),
`endif
        .CNT_HIT(CNT_HIT), .CNT_MISS(CNT_MISS));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Main memory (word addressed) and the reference cache model.
    logic [31:0] mem [MEMW];
    bit          mvalid [NB];
    int          mline  [NB];
    logic [31:0] mdata  [NB][WPB];
    int          m_hit = 0, m_miss = 0;

    // Scoreboard: expected response word + cycle it must appear in (-1 = pending refill).
    logic [31:0] exp_data_q [$];
    int          exp_due_q  [$];
    logic [31:0] addr_q     [$];

    bit resp_block  = 1'b0;
    int fixed_delay = -1;
    bit armed       = 1'b0;
    int wcnt        = 0;
    bit drove       = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Model of one accepted fetch: line = PC / bytes-per-line, index = line mod NB.
    function automatic void model_accept(input logic [31:0] pc);
        int line, idx, off;
        line = int'(pc) / (4 * WPB);
        idx  = line % NB;
        off  = (int'(pc) / 4) % WPB;
        if (mvalid[idx] && mline[idx] == line) begin
            exp_data_q.push_back(mdata[idx][off]);
            exp_due_q.push_back(cyc);
            if (m_hit < CMAX) m_hit++;
        end else begin
            mvalid[idx] = 1'b1;
            mline[idx]  = line;
            for (int w = 0; w < WPB; w++) mdata[idx][w] = mem[line * WPB + w];
            exp_data_q.push_back(mdata[idx][off]);
            exp_due_q.push_back(-1);
            addr_q.push_back(32'(line * WPB * 4));
            if (m_miss < CMAX) m_miss++;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) mvalid[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
        exp_data_q.delete();
        exp_due_q.delete();
        addr_q.delete();
        armed = 1'b0;
    endfunction

    // Called in the post-edge phase; returns in the post-edge phase after acceptance.
    task automatic do_req(input logic [31:0] pc);
        int g = 0;
        PC        = pc;
        req_valid = 1'b1;
        do begin
            @(negedge CLK);
            g++;
        end while (!HitWrite && g < 200);
        if (!HitWrite) begin
            chk("req_accept_timeout", 64'(HitWrite), 64'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge CLK);
            #1;
            model_accept(pc);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((exp_data_q.size() != 0 || addr_q.size() != 0) && g < 100) begin
            @(posedge CLK);
            g++;
        end
        #1;
        chk("drain_timeout", 64'(exp_data_q.size() + addr_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    // Monitor: response timing/data and counters, every cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) continue;
            if (exp_due_q.size() != 0 && exp_due_q[0] >= 0 && exp_due_q[0] < cyc) begin
                void'(exp_data_q.pop_front());
                void'(exp_due_q.pop_front());
            end
            begin
                bit exp_rv;
                exp_rv = (exp_due_q.size() != 0) && (exp_due_q[0] == cyc);
                chk("rvalid", 64'(rvalid), 64'(exp_rv));
                if (rvalid && exp_rv) begin
                    chk("rdata", 64'(rdata), 64'(exp_data_q[0]));
                    void'(exp_data_q.pop_front());
                    void'(exp_due_q.pop_front());
                end
            end
            chk("cnt_hit", 64'(CNT_HIT), 64'(m_hit));
            chk("cnt_miss", 64'(CNT_MISS), 64'(m_miss));
        end
    end

    // Memory responder: checks the refill request and answers after a delay.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (drove) begin
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom};
                drove     = 1'b0;
            end
            if (RESET) continue;
            chk("mem_req", 64'(mem_req), 64'(addr_q.size() != 0));
            if (addr_q.size() != 0) begin
                if (mem_req) chk("mem_addr", 64'(mem_addr), 64'(addr_q[0]));
                if (!resp_block) begin
                    if (!armed) begin
                        armed = 1'b1;
                        wcnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                    end
                    if (wcnt == 0) begin
                        int a;
                        a = int'(addr_q[0]) / 4;
                        mem_ready = 1'b1;
                        mem_rdata = {mem[a + 1], mem[a]};
                        drove     = 1'b1;
                        armed     = 1'b0;
                        exp_due_q[exp_due_q.size() - 1] = cyc + 1;
                        void'(addr_q.pop_front());
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
    end

    initial begin
        RESET     = 1'b1;
        req_valid = 1'b0;
        PC        = '0;
        for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
        mem[16] = 32'hAAAA0000;
        mem[17] = 32'hBBBB0001;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_hitwrite", 64'(HitWrite), 64'd1);
        @(posedge CLK);
        #1;

        // Cold miss, memory answers 3 cycles after mem_req.
        fixed_delay = 3;
        do_req(32'h40);
        wait_idle();
        chk("t1_cnt_miss", 64'(CNT_MISS), 64'd1);

        // Spatial hit on the second word.
        do_req(32'h44);
        wait_idle();
        chk("t2_cnt_hit", 64'(CNT_HIT), 64'd1);

        // Conflict eviction: same index, different tag, then back.
        fixed_delay = 1;
        do_req(32'h60);
        do_req(32'h40);
        wait_idle();
        chk("t3_cnt_miss", 64'(CNT_MISS), 64'd3);

        // Reset mid-refill, then a late mem_ready that must be ignored.
        resp_block = 1'b1;
        do_req(32'h80);
        repeat (3) @(posedge CLK);
        #1;
        do_reset();
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom};
        @(posedge CLK);
        #1;
        mem_ready  = 1'b0;
        resp_block = 1'b0;
        do_req(32'h40);
        wait_idle();
        chk("t4_cnt_miss", 64'(CNT_MISS), 64'd1);

        // Hit counter saturation with back-to-back hits.
        fixed_delay = -1;
        for (int i = 0; i < 20; i++) do_req((i % 2 == 0) ? 32'h40 : 32'h44);
        wait_idle();
        chk("t5_cnt_hit_sat", 64'(CNT_HIT), 64'(CMAX));

`ifdef CACHE_FLUSH_EN
        // Flush blocks a simultaneous request and invalidates the line.
        flush     = 1'b1;
        req_valid = 1'b1;
        PC        = 32'h40;
        @(negedge CLK);
        chk("t6_hitwrite_flush", 64'(HitWrite), 64'd0);
        @(posedge CLK);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < NB; i++) mvalid[i] = 1'b0;
        do_req(32'h40);
        wait_idle();
        chk("t6_cnt_miss", 64'(CNT_MISS), 64'd2);
`endif

        // Random fetch stream with memory updates (stale lines must persist).
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (addr_q.size() == 0 && $urandom_range(0, 7) == 0)
                mem[$urandom_range(0, MEMW - 1)] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
            do_req(32'($urandom_range(0, 255)));
        end
        wait_idle();
        repeat (2) @(posedge CLK);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
